// File: rtl/bcd_serial_alu.sv
// Digit-serial packed-BCD add/subtract controller: one shared single-digit
// adder/corrector stepped LSD first, with ten's-complement fix-up of negative results.
module bcd_serial_alu #(
  parameter int NDIG  = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] S,
  output logic              Cout,
  output logic              neg,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t            state, state_nx;
  logic [4*NDIG-1:0] a_reg, b_reg, w, w_upd;
  logic              op_reg, c;
  logic [CNT_W-1:0]  idx;
  logic [3:0]        a_dig, b_dig, w_dig, x, y, dsum;
  logic [4:0]        t;
  logic              dcout, bad, last;

  assign last = (idx == LAST);

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    w_dig = '0;
    bad   = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == CNT_W'(i)) begin
        a_dig = a_reg[4*i +: 4];
        b_dig = b_reg[4*i +: 4];
        w_dig = w[4*i +: 4];
      end
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Shared digit adder: ADD uses A + (B or 9-B) + c, FIX uses (9-w) + c.
  always_comb begin
    if (state == FIX) begin
      x = 4'd9 - w_dig;
      y = '0;
    end else begin
      x = a_dig;
      y = op_reg ? (4'd9 - b_dig) : b_dig;
    end
    t     = {1'b0, x} + {1'b0, y} + {4'b0, c};
    dcout = (t > 5'd9);
    dsum  = dcout ? 4'(t + 5'd6) : t[3:0];
    w_upd = w;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx == CNT_W'(i)) w_upd[4*i +: 4] = dsum;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = bad ? DONE : ADD;
      ADD:  if (last) state_nx = (op_reg && !dcout) ? FIX : DONE;
      FIX:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == ADD) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      w      <= '0;
      op_reg <= 1'b0;
      c      <= 1'b0;
      idx    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op;
            idx    <= '0;
            c      <= op;
            w      <= '0;
            if (bad) begin
              S    <= '0;
              Cout <= 1'b0;
              neg  <= 1'b0;
              err  <= 1'b1;
            end
          end
        end
        ADD: begin
          w <= w_upd;
          if (last) begin
            idx <= '0;
            // Carry seeds the ten's-complement +1 if FIX follows; otherwise unused.
            c   <= 1'b1;
            if (!(op_reg && !dcout)) begin
              S    <= w_upd;
              Cout <= !op_reg && dcout;
              neg  <= 1'b0;
              err  <= 1'b0;
            end
          end else begin
            idx <= idx + 1'b1;
            c   <= dcout;
          end
        end
        FIX: begin
          w <= w_upd;
          c <= dcout;
          if (last) begin
            idx  <= '0;
            S    <= w_upd;
            Cout <= 1'b0;
            neg  <= 1'b1;
            err  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Self-checking bench for bcd_serial_alu: directed vector table, multi-cycle
// corner sequences and random operations checked against an integer model.
module tb_bcd_serial_alu;
  localparam int NDIG  = 4;
  localparam int CNT_W = 3;
  localparam int W     = 4 * NDIG;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, Cout, neg, err;
  logic [W-1:0] S;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_serial_alu #(.NDIG(NDIG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .neg(neg), .err(err)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a, b, s;
    logic         cout, neg, err;
    int           lat, bsy;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] s, input logic co, input logic ng,
                              input logic er, input int lat, input int bsy);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.s = s; v.cout = co; v.neg = ng; v.err = er;
    v.lat = lat; v.bsy = bsy;
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: decode to integers, compute with plain arithmetic, re-encode.
  function automatic vec_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t e;
    int av, bv, lim, r;
    bit bad;
    av = 0; bv = 0; lim = 1; bad = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) bad = 1;
      av  = av * 10 + int'(a[4*i +: 4]);
      bv  = bv * 10 + int'(b[4*i +: 4]);
      lim = lim * 10;
    end
    e = mk(o, a, b, '0, 1'b0, 1'b0, 1'b0, NDIG + 1, NDIG);
    if (bad) begin
      e.err = 1'b1; e.lat = 1; e.bsy = 0;
    end else if (!o) begin
      r = av + bv;
      e.cout = (r >= lim);
      e.s = to_bcd(r % lim);
    end else if (av >= bv) begin
      e.s = to_bcd(av - bv);
    end else begin
      e.s = to_bcd(bv - av);
      e.neg = 1'b1; e.lat = 2 * NDIG + 1; e.bsy = 2 * NDIG;
    end
    return e;
  endfunction

  task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit pulse, output vec_t r);
    int cnt;
    r = mk(o, a, b, '0, 1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 60) begin
      if (busy) r.bsy++;
      if (pulse && cnt == 2) begin
        start = 1'b1; op = ~o; A = W'($urandom); B = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    r.lat  = done ? cnt : 0;
    r.s    = S;
    r.cout = Cout;
    r.neg  = neg;
    r.err  = err;
  endtask

  task automatic check_res(input string tag, input vec_t r, input vec_t e);
    chk({tag, " S"},       32'(r.s),    32'(e.s));
    chk({tag, " Cout"},    32'(r.cout), 32'(e.cout));
    chk({tag, " neg"},     32'(r.neg),  32'(e.neg));
    chk({tag, " err"},     32'(r.err),  32'(e.err));
    chk({tag, " latency"}, 32'(r.lat),  32'(e.lat));
    chk({tag, " busy"},    32'(r.bsy),  32'(e.bsy));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    vec_t r, e;
    logic [W-1:0] a, b, s_hold;
    logic o;
    int first, second, cnt, dcount;
    logic [W-1:0] s1;
    logic c1;

    tbl[0] = mk(0, 16'h1234, 16'h8766, 16'h0000, 1, 0, 0, 5, 4);
    tbl[1] = mk(1, 16'h5000, 16'h1234, 16'h3766, 0, 0, 0, 5, 4);
    tbl[2] = mk(1, 16'h1234, 16'h5000, 16'h3766, 0, 1, 0, 9, 8);
    tbl[3] = mk(1, 16'h0007, 16'h0007, 16'h0000, 0, 0, 0, 5, 4);
    tbl[4] = mk(0, 16'h12A4, 16'h0001, 16'h0000, 0, 0, 1, 1, 0);
    tbl[5] = mk(0, 16'h0015, 16'h0027, 16'h0042, 0, 0, 0, 5, 4);
    tbl[6] = mk(1, 16'h0000, 16'h0001, 16'h0001, 0, 1, 0, 9, 8);
    tbl[7] = mk(0, 16'h9999, 16'h9999, 16'h9998, 1, 0, 0, 5, 4);
    tbl[8] = mk(1, 16'h0000, 16'h9999, 16'h9999, 0, 1, 0, 9, 8);
    tbl[9] = mk(1, 16'h1000, 16'h0999, 16'h0001, 0, 0, 0, 5, 4);

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset S",    32'(S),    0);
    chk("reset Cout", 32'(Cout), 0);
    chk("reset neg",  32'(neg),  0);
    chk("reset err",  32'(err),  0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, r);
      check_res($sformatf("vec%0d", i), r, tbl[i]);
    end

    // Start pulsed mid-ADD with other operands must be ignored.
    run_op(1'b0, 16'h4567, 16'h1111, 1'b1, r);
    check_res("midpulse", r, mk(0, 16'h4567, 16'h1111, 16'h5678, 0, 0, 0, 5, 4));
    s_hold = S;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("midpulse no extra op", 32'(dcount), 0);
    chk("midpulse S hold", 32'(S), 32'(s_hold));

    // Start held high: second operation accepted in IDLE with new operands.
    @(negedge clk);
    start = 1'b1; op = 1'b0; A = 16'h1234; B = 16'h8766;
    @(posedge clk);
    @(negedge clk);
    A = 16'h0001; B = 16'h0002;
    first = 0; second = 0; cnt = 1; s1 = '0; c1 = 1'b0;
    for (int i = 0; i < 40 && second == 0; i++) begin
      if (done) begin
        if (first == 0) begin
          first = cnt; s1 = S; c1 = Cout;
        end else begin
          second = cnt;
        end
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("held first lat",  32'(first),  5);
    chk("held first S",    32'(s1),     32'h0000);
    chk("held first Cout", 32'(c1),     1);
    chk("held second lat", 32'(second), 11);
    chk("held second S",   32'(S),      32'h0003);
    chk("held second Cout", 32'(Cout),  0);
    repeat (2) @(negedge clk);

    // Reset during FIX cycle 2 (cycle k+6 of a negative subtract).
    @(negedge clk);
    start = 1'b1; op = 1'b1; A = 16'h1234; B = 16'h5000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (cnt < 6) begin
      @(negedge clk);
      cnt++;
    end
    chk("in FIX busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort S",    32'(S),    0);
    chk("abort neg",  32'(neg),  0);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort no done", 32'(dcount), 0);
    run_op(1'b0, 16'h9999, 16'h0001, 1'b0, r);
    check_res("after reset", r, mk(0, 16'h9999, 16'h0001, 16'h0000, 1, 0, 0, 5, 4));

    for (int n = 0; n < 30; n++) begin
      o = 1'($urandom_range(0, 1));
      for (int d = 0; d < NDIG; d++) begin
        a[4*d +: 4] = 4'($urandom_range(0, 9));
        b[4*d +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) a[4*d +: 4] = 4'($urandom_range(10, 15));
        if ($urandom_range(0, 15) == 0) b[4*d +: 4] = 4'($urandom_range(10, 15));
      end
      e = model(o, a, b);
      run_op(o, a, b, 1'b0, r);
      check_res($sformatf("rand%0d", n), r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
